// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - MSB-first word serializer with divisible-by-4 reference output
// Outputs are registered; ready is a combinational decode of the FSM state.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last,
  output logic             exp_det,
  output logic [7:0]       word_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [3:0]    GAP_N    = 4'(GAP);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic [1:0]       rem_q, rem_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_q, last_d;
  logic             exp_det_q, exp_det_d;
  logic             emit;
  logic             ebit;
  logic [1:0]       rem_nx;

  always_comb begin
    ready = (state_q == ST_IDLE) ||
            ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST) && (GAP == 0));
  end

  // cnt_q counts bits already placed on bit_out for the current word
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    rem_d       = rem_q;
    word_cnt_d  = word_cnt_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    last_d      = 1'b0;
    exp_det_d   = 1'b0;
    emit        = 1'b0;
    ebit        = 1'b0;
    rem_nx      = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          emit    = 1'b1;
          ebit    = data_in[WIDTH-1];
          shreg_d = {data_in[WIDTH-2:0], 1'b0};
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          emit    = 1'b1;
          ebit    = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end else begin
          word_cnt_d = word_cnt_q + 8'd1;
          if (GAP > 0) begin
            gap_d   = 4'd1;
            state_d = ST_GAP;
          end else if (load) begin
            emit    = 1'b1;
            ebit    = data_in[WIDTH-1];
            shreg_d = {data_in[WIDTH-2:0], 1'b0};
            cnt_d   = CW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_N) state_d = ST_IDLE;
        else                gap_d   = gap_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      rem_nx      = {rem_q[0], ebit};
      rem_d       = rem_nx;
      bit_out_d   = ebit;
      bit_valid_d = 1'b1;
      last_d      = (cnt_d == CNT_LAST);
      exp_det_d   = (rem_nx == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      rem_q       <= '0;
      word_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      last_q      <= 1'b0;
      exp_det_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      rem_q       <= rem_d;
      word_cnt_q  <= word_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      last_q      <= last_d;
      exp_det_q   <= exp_det_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign last      = last_q;
  assign exp_det   = exp_det_q;
  assign word_cnt  = word_cnt_q;

endmodule
